// File: rtl/newton_recip_iter.sv
// Sequential Newton-Raphson reciprocal: normalise, seed from ROM, refine x = x*(2 - m*x).
// Define NEWTON_RND_EN to round-to-nearest both multiplies instead of truncating.
module newton_recip_iter #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 16,
    parameter int ITER   = 2,
    parameter int ROM_AW = 3,
    parameter int SEED_W = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_data,
    output logic                           rom_rd_en,
    output logic [ROM_AW-1:0]              rom_addr,
    input  logic [SEED_W-1:0]              rom_dout,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [FRAC_W+1:0]              out_mant,
    output logic [$clog2(DATA_W+1)-1:0]    out_exp,
    output logic                           out_dbz
);
    localparam int EXP_W = $clog2(DATA_W + 1);
    localparam int X_W   = FRAC_W + 2;
    localparam int PT_W  = DATA_W + X_W;
    localparam int PX_W  = 2 * X_W;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_NORM = 3'd1;
    localparam logic [2:0] S_SEED = 3'd2;
    localparam logic [2:0] S_MULA = 3'd3;
    localparam logic [2:0] S_MULB = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [X_W-1:0] TWO = X_W'(1) << (FRAC_W + 1);
`ifdef NEWTON_RND_EN
    localparam logic [PT_W-1:0] RND_T = PT_W'(1) << (DATA_W - 1);
    localparam logic [PX_W-1:0] RND_X = PX_W'(1) << (FRAC_W - 1);
`else
    localparam logic [PT_W-1:0] RND_T = '0;
    localparam logic [PX_W-1:0] RND_X = '0;
`endif

    logic [2:0]        state_reg;
    logic [DATA_W-1:0] d_reg;
    logic [DATA_W-1:0] m_reg;
    logic [EXP_W-1:0]  exp_reg;
    logic [X_W-1:0]    x_reg;
    logic [X_W-1:0]    e_reg;
    logic [3:0]        iter_reg;
    logic              out_valid_reg;
    logic [X_W-1:0]    out_mant_reg;
    logic [EXP_W-1:0]  out_exp_reg;
    logic              out_dbz_reg;

    logic [EXP_W-1:0]  lz;
    logic [PT_W-1:0]   prod_t;
    logic [X_W-1:0]    t_val;
    logic [X_W-1:0]    e_next;
    logic [PX_W-1:0]   prod_x;
    logic [X_W+1:0]    x_full;
    logic [X_W-1:0]    x_next;
    logic [X_W-1:0]    x_seed;

    // Highest set bit wins, so scan upward and let later hits overwrite.
    always_comb begin
        lz = EXP_W'(DATA_W);
        for (int i = 0; i < DATA_W; i++) begin
            if (d_reg[i]) begin
                lz = EXP_W'(DATA_W - 1 - i);
            end
        end
    end

    always_comb begin
        prod_t = PT_W'(m_reg) * PT_W'(x_reg) + RND_T;
        t_val  = X_W'(prod_t >> DATA_W);
        e_next = (t_val >= TWO) ? '0 : (TWO - t_val);
        prod_x = PX_W'(x_reg) * PX_W'(e_reg) + RND_X;
        x_full = (X_W + 2)'(prod_x >> FRAC_W);
        x_next = (|x_full[X_W+1:X_W]) ? '1 : x_full[X_W-1:0];
        x_seed = X_W'(rom_dout) << (FRAC_W - SEED_W + 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            d_reg         <= '0;
            m_reg         <= '0;
            exp_reg       <= '0;
            x_reg         <= '0;
            e_reg         <= '0;
            iter_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_mant_reg  <= '0;
            out_exp_reg   <= '0;
            out_dbz_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        if (in_data == '0) begin
                            state_reg     <= S_DONE;
                            out_valid_reg <= 1'b1;
                            out_mant_reg  <= '1;
                            out_exp_reg   <= '0;
                            out_dbz_reg   <= 1'b1;
                        end else begin
                            d_reg     <= in_data;
                            state_reg <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
                    m_reg     <= d_reg << lz;
                    exp_reg   <= EXP_W'(DATA_W) - lz;
                    state_reg <= S_SEED;
                end
                S_SEED: begin
                    x_reg     <= x_seed;
                    iter_reg  <= '0;
                    state_reg <= S_MULA;
                end
                S_MULA: begin
                    e_reg     <= e_next;
                    state_reg <= S_MULB;
                end
                S_MULB: begin
                    x_reg    <= x_next;
                    iter_reg <= iter_reg + 4'd1;
                    if (iter_reg + 4'd1 == 4'(ITER)) begin
                        state_reg     <= S_DONE;
                        out_valid_reg <= 1'b1;
                        out_mant_reg  <= x_next;
                        out_exp_reg   <= exp_reg;
                        out_dbz_reg   <= 1'b0;
                    end else begin
                        state_reg <= S_MULA;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_reg     <= S_IDLE;
                        out_valid_reg <= 1'b0;
                        out_mant_reg  <= '0;
                        out_exp_reg   <= '0;
                        out_dbz_reg   <= 1'b0;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == S_IDLE);
    assign rom_rd_en = (state_reg == S_SEED);
    // Address is forced to 0 outside SEED so the ROM port is quiet between reads.
    assign rom_addr  = (state_reg == S_SEED) ? m_reg[DATA_W-2 -: ROM_AW] : '0;
    assign out_valid = out_valid_reg;
    assign out_mant  = out_mant_reg;
    assign out_exp   = out_exp_reg;
    assign out_dbz   = out_dbz_reg;

endmodule

// File: tb/tb_newton_recip_iter.sv
// Self-checking bench for newton_recip_iter: directed pins plus a random divisor sweep.
module tb_newton_recip_iter;
    localparam int ITER = 2;
    localparam int LAT  = 2 + 2 * ITER + 1;
`ifdef NEWTON_RND_EN
    localparam longint RT = 64'd1 << 15;
    localparam longint RX = 64'd1 << 15;
`else
    localparam longint RT = 0;
    localparam longint RX = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        rom_rd_en;
    logic [2:0]  rom_addr;
    logic [5:0]  rom_dout;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [17:0] out_mant;
    logic [4:0]  out_exp;
    logic        out_dbz;

    logic [5:0] rom [8];
    assign rom_dout = rom[rom_addr];

    always #5 clk = ~clk;

    newton_recip_iter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant),
        .out_exp(out_exp), .out_dbz(out_dbz)
    );

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: 1/d = (1/m) * 2^-(msb+1) with m = d / 2^(msb+1) in [0.5,1).
    task automatic model(input logic [15:0] d, output longint mant, output int e,
                         output bit dbz, output int addr);
        longint m, x, t, ee, p;
        int msb;
        mant = 0; e = 0; dbz = 0; addr = 0;
        if (d == 0) begin
            mant = (64'd1 << 18) - 1;
            dbz = 1;
        end else begin
            msb = 0;
            for (int i = 0; i < 16; i++) if (d[i]) msb = i;
            e = msb + 1;
            m = longint'(d) << (15 - msb);
            addr = int'((m >> 12) & 7);
            x = longint'(rom[addr]) << 11;
            for (int k = 0; k < ITER; k++) begin
                t  = (m * x + RT) >> 16;
                ee = (t >= (64'd1 << 17)) ? 0 : (64'd1 << 17) - t;
                p  = (x * ee + RX) >> 16;
                x  = (p >= (64'd1 << 18)) ? (64'd1 << 18) - 1 : p;
            end
            mant = x;
        end
    endtask

    // Monitor state
    bit     rst_q = 1'b1;
    bit     busy = 0;
    int     cyc = 0, acc_cyc = 0, dt = 0, rd_cnt = 0;
    longint e_mant; int e_exp; bit e_dbz; int e_addr; int e_lat;
    logic [15:0] e_d;
    longint cap_mant; int cap_exp; bit cap_dbz; int cap_addr; int cap_rd;

    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin
        cyc++;
        if (rst_q) begin
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_rom_rd_en", rom_rd_en, 0);
            chk("rst_rom_addr", rom_addr, 0);
            chk("rst_out_mant", out_mant, 0);
            chk("rst_out_exp", out_exp, 0);
            chk("rst_out_dbz", out_dbz, 0);
            busy = 0;
        end else begin
            if (busy) begin
                dt = cyc - acc_cyc;
                chk("rom_rd_en", rom_rd_en, (dt == 2 && !e_dbz) ? 1 : 0);
                if (rom_rd_en) begin
                    chk("rom_addr", rom_addr, e_addr);
                    cap_addr = rom_addr;
                    rd_cnt++;
                end
                if (dt < e_lat) begin
                    chk("early_valid", out_valid, 0);
                    chk("busy_in_ready", in_ready, 0);
                end else begin
                    chk("out_valid", out_valid, 1);
                    chk("out_mant", out_mant, e_mant);
                    chk("out_exp", out_exp, e_exp);
                    chk("out_dbz", out_dbz, e_dbz);
                    chk("done_in_ready", in_ready, 0);
                    if (dt == e_lat) begin
                        cap_mant = out_mant; cap_exp = out_exp; cap_dbz = out_dbz; cap_rd = rd_cnt;
                        $display("op d=0x%04h mant=0x%05h exp=%0d dbz=%0d", e_d, out_mant, out_exp, out_dbz);
                    end
                    if ((out_valid && out_ready) || dt > e_lat + 60) busy = 0;
                end
            end else begin
                chk("idle_in_ready", in_ready, 1);
                chk("idle_out_valid", out_valid, 0);
                chk("idle_rom_rd_en", rom_rd_en, 0);
                chk("idle_out_mant", out_mant, 0);
                chk("idle_out_exp", out_exp, 0);
                chk("idle_out_dbz", out_dbz, 0);
            end
            if (!busy && in_valid && in_ready) begin
                busy = 1;
                acc_cyc = cyc;
                rd_cnt = 0;
                e_d = in_data;
                model(in_data, e_mant, e_exp, e_dbz, e_addr);
                e_lat = e_dbz ? 1 : LAT;
            end
        end
    end

    task automatic do_op(input logic [15:0] d, input int hold, input bit pulse);
        int n;
        n = 0;
        while (!in_ready && n < 30) begin @(posedge clk); #2; n++; end
        chk("wait_in_ready", in_ready, 1);
        out_ready = (hold == 0);
        in_valid = 1'b1;
        in_data = d;
        @(posedge clk); #2;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #2; n++; end
        chk("wait_out_valid", out_valid, 1);
        for (int k = 0; k < hold; k++) begin
            if (pulse) begin in_valid = k[0]; in_data = 16'($urandom); end
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #2;
    endtask

    longint pm; int pe; bit pz; int pa;
    longint mant_d1;
    int hold;

    initial begin
        rom[0] = 6'h3c; rom[1] = 6'h2f; rom[2] = 6'h26; rom[3] = 6'h20;
        rom[4] = 6'h1b; rom[5] = 6'h17; rom[6] = 6'h14; rom[7] = 6'h11;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2;

        // Hand-derived: x0=0x1E000 -> 0x1FE00 -> 0x1FFFE (all products exact).
        model(16'd1, pm, pe, pz, pa);
        chk("model_d1_mant", pm, 64'h1FFFE);
        chk("model_d1_exp", pe, 1);

        do_op(16'h0001, 0, 0);
        mant_d1 = cap_mant;
        chk("d1_mant", cap_mant, 64'h1FFFE);
        chk("d1_near_two", ((64'h20000 - cap_mant) <= 2) ? 1 : 0, 1);
        chk("d1_exp", cap_exp, 1);
        chk("d1_rom_addr", cap_addr, 0);
        chk("d1_rom_reads", cap_rd, 1);

        do_op(16'h8000, 0, 0);
        chk("d8000_exp", cap_exp, 16);
        chk("d8000_mant_eq_d1", cap_mant, mant_d1);

        do_op(16'h0000, 0, 0);
        chk("d0_mant", cap_mant, 64'h3FFFF);
        chk("d0_exp", cap_exp, 0);
        chk("d0_dbz", cap_dbz, 1);
        chk("d0_rom_reads", cap_rd, 0);

        do_op(16'h00ff, 5, 1);

        // Abort an op while it sits in MULA.
        in_valid = 1'b1; in_data = 16'h1234;
        @(posedge clk); #2 in_valid = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #2;

        do_op(16'h0003, 0, 0);
        chk("d3_exp", cap_exp, 2);
        chk("d3_rom_addr", cap_addr, 4);

        for (int i = 0; i < 2500; i++) begin
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_op(16'($urandom) >> $urandom_range(0, 15), hold, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
